seq_multiplier: RTL and testbench

//  Multi-cycle shift-and-add multiplier for the execute stage (RV32M MUL/MULH/MULHSU/MULHU).

---
 rtl/seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_seq_multiplier.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes, then fixes the sign of the double-width product once at the end.
module seq_multiplier_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic carry;
    logic bx;
    always_comb begin
        sum   = '0;
        carry = sub;
        bx    = 1'b0;
        for (int i = 0; i < N; i++) begin
            bx     = b[i] ^ sub;
            sum[i] = a[i] ^ bx ^ carry;
            carry  = (a[i] & bx) | (carry & (a[i] ^ bx));
        end
    end
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [WIDTH-1:0]     o_q, o_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH:0]       add_a, add_b, add_sum;
    logic                 a_neg, b_neg;
    logic [2*WIDTH-1:0]   fixed;

    assign a_neg = a[WIDTH-1] & ((op == 2'b01) | (op == 2'b10));
    assign b_neg = b[WIDTH-1] & (op == 2'b01);
    assign add_a = {1'b0, product_q[2*WIDTH-1:WIDTH]};
    assign add_b = mult_q[0] ? {1'b0, mag_a_q} : '0;
    assign fixed = neg_q ? (~product_q + (2*WIDTH)'(1)) : product_q;

    seq_multiplier_adder #(.N(WIDTH + 1)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sub (1'b0),
        .sum (add_sum)
    );

    // out_valid lags DONE entry by one cycle so it is a pure decode of registered state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        neg_d       = neg_q;
        mag_a_d     = mag_a_q;
        mult_d      = mult_q;
        product_d   = product_q;
        count_d     = count_q;
        o_d         = o_q;
        out_valid_d = 1'b0;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_d      = op;
                    neg_d     = a_neg ^ b_neg;
                    mag_a_d   = a_neg ? -a : a;
                    mult_d    = b_neg ? -b : b;
                    product_d = '0;
                    count_d   = '0;
                    state_d   = CALC;
                end
                CALC: begin
                    product_d = {add_sum, product_q[WIDTH-1:1]};
                    mult_d    = mult_q >> 1;
                    count_d   = count_q + CW'(1);
                    state_d   = (count_q == CW'(WIDTH - 1)) ? FIX : CALC;
                end
                FIX: begin
                    product_d = fixed;
                    o_d       = (op_q == 2'b00) ? fixed[WIDTH-1:0] : fixed[2*WIDTH-1:WIDTH];
                    state_d   = DONE;
                end
                default: begin
                    state_d     = (out_valid_q & out_ready) ? IDLE : DONE;
                    out_valid_d = ~(out_valid_q & out_ready);
                end
            endcase
        end
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            mag_a_q     <= '0;
            mult_q      <= '0;
            product_q   <= '0;
            count_q     <= '0;
            o_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            mag_a_q     <= mag_a_d;
            mult_q      <= mult_d;
            product_q   <= product_d;
            count_q     <= count_d;
            o_q         <= o_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o         = o_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier results, latency, handshake, kill and reset.
module tb_seq_multiplier;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] o_p, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("start_ready", W'(in_ready), W'(1));
        op = o_p;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic ir_bad);
        lat = 0;
        ir_bad = 1'b0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            if (in_ready) ir_bad = 1'b1;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o_p, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp);
        int lat;
        logic ir_bad;
        start(o_p, x, y);
        wait_done(lat, ir_bad);
        chk({tag, "_latency"}, W'(lat), W'(34));
        chk({tag, "_busy_ready"}, W'(ir_bad), W'(0));
        chk({tag, "_o"}, o, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, W'(out_valid), W'(0));
        chk({tag, "_ready_back"}, W'(in_ready), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        logic ir_bad;
        logic bad;
        tick();
        tick();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_o", o, '0);
        rst_n = 1'b1;
        tick();

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A);
        do_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        do_op("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("mulh_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
        do_op("mulhu_carry", 2'b11, 32'h8000_0000, 32'd2, 32'h0000_0001);
        do_op("mulhsu_mixed", 2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF);

        // Back-pressure: result must hold while ignored in_valid pulses arrive.
        start(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, ir_bad);
        chk("hold_latency", W'(lat), W'(34));
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 2'b00;
            a = 32'd1;
            b = 32'd1;
            in_valid = i[0];
            tick();
            if (!out_valid || o !== 32'hFFFF_FFFE || in_ready) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("hold_stable", W'(bad), W'(0));
        chk("hold_o", o, 32'hFFFF_FFFE);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release", W'(out_valid), W'(0));
        do_op("after_hold", 2'b00, 32'd5, 32'd5, 32'd25);

        // Kill at count 10 of CALC.
        start(2'b00, 32'd100, 32'd100);
        repeat (10) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_calc_ready", W'(in_ready), W'(1));
        chk("kill_calc_valid", W'(out_valid), W'(0));
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) bad = 1'b1;
        end
        chk("kill_no_result", W'(bad), W'(0));
        do_op("mul_3xm2", 2'b00, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA);

        // Kill in IDLE overrides in_valid.
        op = 2'b00;
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        kill = 1'b1;
        tick();
        in_valid = 1'b0;
        kill = 1'b0;
        repeat (3) tick();
        chk("kill_idle_ready", W'(in_ready), W'(1));
        chk("kill_idle_valid", W'(out_valid), W'(0));

        // Kill together with out_ready in DONE.
        start(2'b00, 32'd11, 32'd13);
        wait_done(lat, ir_bad);
        chk("kd_o", o, 32'd143);
        kill = 1'b1;
        out_ready = 1'b1;
        tick();
        kill = 1'b0;
        out_ready = 1'b0;
        chk("kd_valid", W'(out_valid), W'(0));
        chk("kd_ready", W'(in_ready), W'(1));

        // Async reset in the middle of CALC.
        start(2'b00, 32'd11, 32'd13);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(out_valid), W'(0));
        chk("arst_ready", W'(in_ready), W'(1));
        chk("arst_o", o, '0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("after_rst", 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
